dmem_lsu: RTL and testbench

//  Load/store initiator between the pipeline MEM stage and the word-wide Data_Memory.

---
 rtl/dmem_lsu.sv | 138 +++++++++++++
 tb/tb_dmem_lsu.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the pipeline MEM stage and a word-wide data memory.
// Byte/half/word loads with sign or zero extension; sub-word stores use read-modify-write.
// One request in flight at a time. The pipeline stalls while req_ready is low.
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   req_valid/req_ready       request handshake; accepted only in the idle state
//   req_we, req_size          1 = store; size 00 = byte, 01 = half, 10 = word, 11 = illegal
//   req_unsigned              zero-extend loads when 1, sign-extend when 0
//   req_addr, req_wdata       byte address and right-aligned store data
//   resp_valid/err/rdata      one-cycle completion pulse with error flag and load result
//   mem_addr/wdata/we/rdata   word-aligned memory port; mem_rdata is combinational
module dmem_lsu #(
  parameter int unsigned ADDR_W        = 32,
  parameter bit          MISALIGN_TRAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e state_q, state_d;

  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic              err_q;

  logic              illegal, misalign, req_err;
  logic [ADDR_W-1:0] addr_eff;

  // Request decode: errors and the effective address when misalignment is not trapped.
  always_comb begin
    illegal  = (req_size == 2'b11);
    misalign = ((req_size == 2'b01) && req_addr[0]) ||
               ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    req_err  = illegal || (MISALIGN_TRAP && misalign);
    addr_eff = req_addr;
    if (!MISALIGN_TRAP) begin
      if (req_size == 2'b01) addr_eff[0] = 1'b0;
      if (req_size == 2'b10) addr_eff[1:0] = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && req_valid) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= addr_eff;
        wdata_q <= req_wdata;
        err_q   <= req_err;
      end
      if (state_q == StRd) word_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_err)                               state_d = StResp;
          else if (!req_we || (req_size != 2'b10))   state_d = StRd;
          else                                       state_d = StWr;
        end
      end
      StRd:    state_d = we_q ? StWr : StResp;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Lane extraction for loads and lane replacement for sub-word stores (little-endian).
  always_comb begin
    byte_sel = word_q[{addr_q[1:0], 3'b000} +: 8];
    half_sel = word_q[{addr_q[1], 4'b0000} +: 16];
    unique case (size_q)
      2'b00:   load_val = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_val = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_val = word_q;
    endcase

    merged = word_q;
    unique case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_err   = resp_valid && err_q;
    resp_rdata = (resp_valid && !we_q && !err_q) ? load_val : 32'h0;
    mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    // Gating with rst drops the write if reset lands on the WR cycle.
    mem_we     = (state_q == StWr) && !rst;
    mem_wdata  = (state_q == StWr) ? merged : 32'h0;
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Testbench for dmem_lsu: transaction-level reference model plus a per-cycle compare process,
// directed cases with literal expectations, and randomized loads/stores.
module tb_dmem_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  // Second instance with misalignment trapping disabled.
  logic        r2_valid, r2_ready, r2_resp_valid, r2_resp_err, r2_mem_we;
  logic [31:0] r2_addr, r2_resp_rdata, r2_mem_addr, r2_mem_wdata, r2_mem_rdata;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];

  dmem_lsu #(.ADDR_W(32), .MISALIGN_TRAP(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  dmem_lsu #(.ADDR_W(32), .MISALIGN_TRAP(1'b0)) dut_notrap (
    .clk(clk), .rst(rst), .req_valid(r2_valid), .req_ready(r2_ready), .req_we(1'b0),
    .req_size(2'b10), .req_unsigned(1'b0), .req_addr(r2_addr), .req_wdata(32'h0),
    .resp_valid(r2_resp_valid), .resp_err(r2_resp_err), .resp_rdata(r2_resp_rdata),
    .mem_addr(r2_mem_addr), .mem_wdata(r2_mem_wdata), .mem_we(r2_mem_we),
    .mem_rdata(r2_mem_rdata)
  );

  assign mem_rdata    = mem[mem_addr[5:2]];
  assign r2_mem_rdata = mem[r2_mem_addr[5:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[5:2]] = mem_wdata;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_err(input logic [1:0] sz, input logic [1:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a != 2'd0);
  endfunction

  function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] sz, input bit uns);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * a)) & 32'hff;
      if (!uns && v[7]) v = v | 32'hffffff00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * a[1])) & 32'hffff;
      if (!uns && v[15]) v = v | 32'hffff0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] a,
                                        input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] m;
    if (sz == 2'd0) begin
      m = 32'hff << (8 * a);
      return (w & ~m) | ((wd & 32'hff) << (8 * a));
    end else if (sz == 2'd1) begin
      m = 32'hffff << (16 * a[1]);
      return (w & ~m) | ((wd & 32'hffff) << (16 * a[1]));
    end
    return wd;
  endfunction

  // Reference model: one transaction at a time, timed in cycles since acceptance.
  bit          started = 0;
  bit          m_active = 0;
  int          m_cyc, m_lat, m_idx;
  bit          m_wr, m_rd, m_err;
  logic [31:0] m_rdata, m_wword, m_addr;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0;
      started  = 1;
    end else if (!m_active) begin
      if (req_valid) begin
        m_active = 1;
        m_cyc    = 1;
        m_addr   = req_addr;
        m_idx    = int'(req_addr[5:2]);
        m_err    = is_err(req_size, req_addr[1:0]);
        m_wr     = 0;
        m_rd     = 0;
        m_rdata  = 32'h0;
        m_wword  = 32'h0;
        if (m_err) begin
          m_lat = 1;
        end else if (!req_we) begin
          m_lat   = 2;
          m_rd    = 1;
          m_rdata = ext_load(ref_mem[m_idx], req_addr[1:0], req_size, req_unsigned);
        end else if (req_size == 2'd2) begin
          m_lat   = 2;
          m_wr    = 1;
          m_wword = req_wdata;
        end else begin
          m_lat   = 3;
          m_rd    = 1;
          m_wr    = 1;
          m_wword = merge(ref_mem[m_idx], req_addr[1:0], req_size, req_wdata);
        end
      end
    end else begin
      if (m_wr && m_cyc == m_lat - 1) ref_mem[m_idx] = m_wword;
      if (m_cyc == m_lat) m_active = 0;
      else m_cyc++;
    end
  end

  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;
  int          n_resp = 0;
  int          n_we = 0;
  bit          exp_rv, exp_we;

  always @(negedge clk) begin
    if (started) begin
      chk("req_ready", {31'h0, req_ready}, {31'h0, !m_active});
      exp_rv = m_active && (m_cyc == m_lat);
      chk("resp_valid", {31'h0, resp_valid}, {31'h0, exp_rv});
      if (resp_valid) begin
        last_rdata = resp_rdata;
        last_err   = resp_err;
        last_lat   = m_cyc;
        n_resp++;
      end
      if (exp_rv) begin
        chk("resp_err", {31'h0, resp_err}, {31'h0, m_err});
        chk("resp_rdata", resp_rdata, m_rdata);
      end
      exp_we = m_active && m_wr && (m_cyc == m_lat - 1) && !rst;
      chk("mem_we", {31'h0, mem_we}, {31'h0, exp_we});
      if (mem_we) n_we++;
      if (exp_we) begin
        chk("mem_wdata", mem_wdata, m_wword);
        chk("mem_addr wr", mem_addr, {m_addr[31:2], 2'b00});
      end
      if (m_active && m_rd && m_cyc == 1 && !rst) chk("mem_addr rd", mem_addr, {m_addr[31:2], 2'b00});
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (m_active && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (m_active) chk("idle timeout", 32'h1, 32'h0);
  endtask

  task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] ad, input logic [31:0] wd);
    wait_idle();
    req_valid = 1'b1;
    req_we = we;
    req_size = sz;
    req_unsigned = uns;
    req_addr = ad;
    req_wdata = wd;
    @(posedge clk); #1;
    // Scramble the request fields while busy; they must be ignored.
    req_valid = 1'b0;
    req_we = 1'($urandom);
    req_size = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  task automatic txn(input bit we, input logic [1:0] sz, input bit uns,
                     input logic [31:0] ad, input logic [31:0] wd);
    do_req(we, sz, uns, ad, wd);
    wait_idle();
  endtask

  int snap;

  initial begin
    rst = 1'b1;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_size = 2'd2;
    req_unsigned = 1'b0;
    req_addr = 32'h10;
    req_wdata = 32'h0;
    r2_valid = 1'b0;
    r2_addr = 32'h0;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);

    // Reset held two cycles with a pending request.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset req_ready", {31'h0, req_ready}, 32'h1);
    chk("reset resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("reset mem_we", {31'h0, mem_we}, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    rst = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("no accept in reset", {31'h0, req_ready}, 32'h1);
    chk("no resp after reset", n_resp, 0);

    // Word load.
    set_word(4, 32'hDEADBEEF);
    txn(0, 2'd2, 0, 32'h10, 32'h0);
    chk("LW rdata", last_rdata, 32'hDEADBEEF);
    chk("LW err", {31'h0, last_err}, 32'h0);
    chk("LW latency", last_lat, 2);

    // Sub-word loads with extension.
    set_word(4, 32'h80FF1234);
    txn(0, 2'd0, 0, 32'h13, 32'h0);
    chk("LB", last_rdata, 32'hFFFFFF80);
    txn(0, 2'd0, 1, 32'h13, 32'h0);
    chk("LBU", last_rdata, 32'h00000080);
    txn(0, 2'd1, 0, 32'h12, 32'h0);
    chk("LH", last_rdata, 32'hFFFF80FF);
    txn(0, 2'd1, 1, 32'h12, 32'h0);
    chk("LHU", last_rdata, 32'h000080FF);

    // Sub-word stores via read-modify-write.
    set_word(4, 32'h11223344);
    txn(1, 2'd0, 0, 32'h11, 32'h000000AB);
    chk("SB word", mem[4], 32'h1122AB44);
    chk("SB latency", last_lat, 3);
    set_word(4, 32'h11223344);
    txn(1, 2'd1, 0, 32'h12, 32'h0000BEEF);
    chk("SH word", mem[4], 32'hBEEF3344);
    txn(1, 2'd2, 0, 32'h14, 32'hA5A5_5A5A);
    chk("SW word", mem[5], 32'hA5A55A5A);
    chk("SW latency", last_lat, 2);

    // Misaligned word load traps.
    snap = n_we;
    txn(0, 2'd2, 0, 32'h06, 32'h0);
    chk("LW misaligned err", {31'h0, last_err}, 32'h1);
    chk("LW misaligned rdata", last_rdata, 32'h0);
    chk("LW misaligned latency", last_lat, 1);
    chk("LW misaligned no write", n_we, snap);

    // Without trapping the low bits are cleared and the load proceeds.
    set_word(1, 32'hCAFEF00D);
    r2_valid = 1'b1;
    r2_addr = 32'h06;
    @(posedge clk); #1;
    r2_valid = 1'b0;
    chk("notrap mem_addr", r2_mem_addr, 32'h04);
    chk("notrap rd resp_valid", {31'h0, r2_resp_valid}, 32'h0);
    @(posedge clk); #1;
    chk("notrap resp_valid", {31'h0, r2_resp_valid}, 32'h1);
    chk("notrap err", {31'h0, r2_resp_err}, 32'h0);
    chk("notrap rdata", r2_resp_rdata, 32'hCAFEF00D);

    // Reset landing on the WR cycle of a half store.
    set_word(4, 32'h11223344);
    do_req(1, 2'd1, 0, 32'h12, 32'h00005555);
    @(posedge clk); #1;
    rst = 1'b1;
    snap = n_resp;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst-in-WR req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst-in-WR memory", mem[4], 32'h11223344);
    @(posedge clk); #1;
    chk("rst-in-WR no resp", n_resp, snap);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      do_req(1'($urandom), ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
             1'($urandom), 32'($urandom_range(0, 63)), $urandom);
    end
    wait_idle();
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) chk("final memory", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
